// File: rtl/alu_irq_pipe_pkg.sv
// alu_pkg: shared ALU types, the bitwise opcode function and the match-table index helper.
package alu_pkg;
    localparam int MAX_W = 64;
    typedef enum logic {BANK_A = 1'b0, BANK_B = 1'b1} bank_e;
    typedef logic [1:0] op_t;
    typedef logic [2:0] idx_t;
    // Operands are widened to MAX_W so one function serves every WIDTH; callers keep the low bits
    function automatic logic [MAX_W-1:0] alu_compute(bank_e bank, op_t op, logic [MAX_W-1:0] a, logic [MAX_W-1:0] b);
        if (bank == BANK_A)
            return op == 2'd0 ? a & b : op == 2'd1 ? ~(a & b) : op == 2'd2 ? a | b : a ^ b;
        return op == 2'd0 ? ~(a ^ b) : op == 2'd1 ? a & b : op == 2'd2 ? ~(a | b) : a | b;
    endfunction
    function automatic idx_t entry_idx(bank_e bank, op_t op);
        return {bank, op};
    endfunction
endpackage

// File: rtl/alu_irq_pipe_if.sv
// alu_irq_pipe_if: operand/result handshake, match-table config and interrupt signals of the ALU pipe.
interface alu_irq_pipe_if import alu_pkg::*; #(parameter int WIDTH = 8, parameter int COUNT_W = 8);
    logic               in_valid;
    logic               in_ready;
    logic               in_bank;
    op_t                in_op;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_match;
    logic               cfg_we;
    idx_t               cfg_sel;
    logic               cfg_en;
    logic [WIDTH-1:0]   cfg_data;
    logic               irq;
    logic               irq_clr;
    logic [COUNT_W-1:0] irq_count;
    modport slave (
        input  in_valid, in_bank, in_op, in_a, in_b, out_ready, cfg_we, cfg_sel, cfg_en, cfg_data, irq_clr,
        output in_ready, out_valid, out_data, out_match, irq, irq_count
    );
    modport master (
        output in_valid, in_bank, in_op, in_a, in_b, out_ready, cfg_we, cfg_sel, cfg_en, cfg_data, irq_clr,
        input  in_ready, out_valid, out_data, out_match, irq, irq_count
    );
endinterface

// File: rtl/alu_irq_ctrl.sv
// alu_irq_ctrl: match table, result comparator, sticky irq and saturating match counter.
module alu_irq_ctrl import alu_pkg::*; #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 8
) (
    input  logic               alu_clk,
    input  logic               rst_n,
    input  logic               load,
    input  idx_t               load_sel,
    input  logic [WIDTH-1:0]   result,
    output logic               match,
    input  logic               cfg_we,
    input  idx_t               cfg_sel,
    input  logic               cfg_en,
    input  logic [WIDTH-1:0]   cfg_data,
    input  logic               irq_clr,
    output logic               irq,
    output logic [COUNT_W-1:0] irq_count
);
    logic [7:0]            en_q, en_d;
    logic [7:0][WIDTH-1:0] val_q, val_d;
    logic                  irq_q, irq_d;
    logic [COUNT_W-1:0]    cnt_q, cnt_d;
    logic                  hit;
    // Compare against the registered table so a same-cycle write never affects the loading result
    assign match = en_q[load_sel] & (result == val_q[load_sel]);
    assign hit   = load & match;
    always_comb begin
        en_d  = en_q;
        val_d = val_q;
        if (cfg_we) begin
            en_d[cfg_sel]  = cfg_en;
            val_d[cfg_sel] = cfg_data;
        end
        irq_d = hit | (irq_q & ~irq_clr);
        cnt_d = (hit && cnt_q != '1) ? cnt_q + COUNT_W'(1) : cnt_q;
    end
    always_ff @(posedge alu_clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q  <= '0;
            val_q <= '0;
            irq_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            en_q  <= en_d;
            val_q <= val_d;
            irq_q <= irq_d;
            cnt_q <= cnt_d;
        end
    end
    assign irq       = irq_q;
    assign irq_count = cnt_q;
endmodule

// File: rtl/alu_irq_pipe.sv
// alu_irq_pipe: two-stage back-pressured bitwise ALU pipeline with match-driven sticky interrupt.
module alu_irq_pipe import alu_pkg::*; #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 8
) (
    input logic           alu_clk,
    input logic           rst_n,
    alu_irq_pipe_if.slave bus
);
    logic             s1_valid_q, s1_valid_d;
    bank_e            s1_bank_q, s1_bank_d;
    op_t              s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q, s2_data_d;
    logic             s2_match_q, s2_match_d;
    logic             rdy1, rdy2, take, load2, match;
    logic [MAX_W-1:0] full;
    logic [WIDTH-1:0] result;
    assign rdy2   = !s2_valid_q | bus.out_ready;
    assign rdy1   = !s1_valid_q | rdy2;
    assign take   = bus.in_valid & rdy1;
    assign load2  = s1_valid_q & rdy2;
    assign full   = alu_compute(s1_bank_q, s1_op_q, MAX_W'(s1_a_q), MAX_W'(s1_b_q));
    assign result = full[WIDTH-1:0];
    always_comb begin
        s1_valid_d = rdy1 ? bus.in_valid : s1_valid_q;
        s1_bank_d  = take ? bank_e'(bus.in_bank) : s1_bank_q;
        s1_op_d    = take ? bus.in_op : s1_op_q;
        s1_a_d     = take ? bus.in_a : s1_a_q;
        s1_b_d     = take ? bus.in_b : s1_b_q;
        s2_valid_d = rdy2 ? s1_valid_q : s2_valid_q;
        s2_data_d  = load2 ? result : s2_data_q;
        s2_match_d = load2 ? match : s2_match_q;
    end
    always_ff @(posedge alu_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_bank_q  <= BANK_A;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_match_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_bank_q  <= s1_bank_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_match_q <= s2_match_d;
        end
    end
    alu_irq_ctrl #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) u_ctrl (
        .alu_clk   (alu_clk),
        .rst_n     (rst_n),
        .load      (load2),
        .load_sel  (entry_idx(s1_bank_q, s1_op_q)),
        .result    (result),
        .match     (match),
        .cfg_we    (bus.cfg_we),
        .cfg_sel   (bus.cfg_sel),
        .cfg_en    (bus.cfg_en),
        .cfg_data  (bus.cfg_data),
        .irq_clr   (bus.irq_clr),
        .irq       (bus.irq),
        .irq_count (bus.irq_count)
    );
    assign bus.in_ready  = rdy1;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_match = s2_match_q;
endmodule

// File: tb/tb_alu_irq_pipe.sv
// tb_alu_irq_pipe: directed and random stimulus against a queue-based reference of the ALU pipe.
module tb_alu_irq_pipe;
    localparam int W = 8;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;
    typedef struct {
        logic [W-1:0] d;
        logic [2:0]   idx;
        bit           loaded;
        bit           m;
    } item_t;
    logic alu_clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    item_t q[$];
    bit mt_en[8];
    logic [W-1:0] mt_val[8];
    bit m_irq;
    int m_cnt;
    always #5 alu_clk = ~alu_clk;
    alu_irq_pipe_if #(.WIDTH(W), .COUNT_W(CW)) bus();
    alu_irq_pipe #(.WIDTH(W), .COUNT_W(CW)) dut (.alu_clk(alu_clk), .rst_n(rst_n), .bus(bus));
    function automatic logic [W-1:0] ref_alu(bit bank, bit [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        case ({bank, op})
            3'b000: return a & b;
            3'b001: return ~(a & b);
            3'b010: return a | b;
            3'b011: return a ^ b;
            3'b100: return ~(a ^ b);
            3'b101: return a & b;
            3'b110: return ~(a | b);
            default: return a | b;
        endcase
    endfunction
    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0: return 8'h00;
            1: return 8'hFF;
            2: return 8'h0F;
            3: return 8'hF0;
            default: return W'($urandom);
        endcase
    endfunction
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic apply_reset();
        rst_n = 1'b0;
        q.delete();
        for (int i = 0; i < 8; i++) begin
            mt_en[i] = 1'b0;
            mt_val[i] = '0;
        end
        m_irq = 1'b0;
        m_cnt = 0;
    endtask
    task automatic send(bit bank, bit [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        bus.in_valid = 1'b1;
        bus.in_bank = bank;
        bus.in_op = op;
        bus.in_a = a;
        bus.in_b = b;
    endtask
    task automatic step();
        bit exp_rdy, exp_ov, hit;
        item_t it;
        #1;
        exp_rdy = (q.size() < 2) || bus.out_ready;
        exp_ov = (q.size() > 0) && q[0].loaded;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        if (exp_ov) begin
            chk("out_data", 32'(bus.out_data), 32'(q[0].d));
            chk("out_match", 32'(bus.out_match), 32'(q[0].m));
        end
        chk("irq", 32'(bus.irq), 32'(m_irq));
        chk("irq_count", 32'(bus.irq_count), 32'(m_cnt));
        @(posedge alu_clk);
        if (rst_n) begin
            hit = 1'b0;
            if (exp_ov && bus.out_ready) void'(q.pop_front());
            if (q.size() > 0 && !q[0].loaded) begin
                it = q[0];
                it.loaded = 1'b1;
                it.m = mt_en[it.idx] && (it.d == mt_val[it.idx]);
                hit = it.m;
                q[0] = it;
            end
            m_irq = hit || (m_irq && !bus.irq_clr);
            if (hit && m_cnt < CMAX) m_cnt++;
            if (bus.cfg_we) begin
                mt_en[bus.cfg_sel] = bus.cfg_en;
                mt_val[bus.cfg_sel] = bus.cfg_data;
            end
            if (bus.in_valid && exp_rdy) begin
                it.d = ref_alu(bus.in_bank, bus.in_op, bus.in_a, bus.in_b);
                it.idx = {bus.in_bank, bus.in_op};
                it.loaded = 1'b0;
                it.m = 1'b0;
                q.push_back(it);
            end
        end
        @(negedge alu_clk);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end
    initial begin
        bus.in_valid = 0; bus.in_bank = 0; bus.in_op = 0; bus.in_a = 0; bus.in_b = 0;
        bus.out_ready = 1; bus.cfg_we = 0; bus.cfg_sel = 0; bus.cfg_en = 0; bus.cfg_data = 0; bus.irq_clr = 0;
        apply_reset();
        @(negedge alu_clk);
        repeat (3) begin
            bus.in_valid = 1'($urandom); bus.in_a = W'($urandom); bus.in_b = W'($urandom);
            bus.cfg_we = 1'($urandom); bus.irq_clr = 1'($urandom); bus.out_ready = 1'($urandom);
            #1 chk("rst_out_data", 32'(bus.out_data), 0);
            chk("rst_out_match", 32'(bus.out_match), 0);
            step();
        end
        bus.in_valid = 0; bus.cfg_we = 0; bus.irq_clr = 0; bus.out_ready = 1;
        rst_n = 1'b1;
        repeat (2) step();
        send(0, 2'b00, 8'hF0, 8'h3C); step();
        send(1, 2'b10, 8'h0F, 8'h30); step();
        bus.in_valid = 0;
        #1 chk("cmp_a00_data", 32'(bus.out_data), 32'h30);
        step();
        #1 chk("cmp_b10_valid", 32'(bus.out_valid), 1);
        chk("cmp_b10_data", 32'(bus.out_data), 32'hC0);
        repeat (2) step();
        bus.out_ready = 0;
        send(0, 2'b11, 8'h11, 8'h22); step();
        send(1, 2'b00, 8'h33, 8'h44); step();
        send(1, 2'b11, 8'h55, 8'h66);
        #1 chk("bp_full_in_ready", 32'(bus.in_ready), 0);
        step();
        bus.out_ready = 1; step();
        bus.in_valid = 0;
        #1 chk("bp_order_second", 32'(bus.out_data), 32'h88);
        repeat (4) step();
        bus.cfg_we = 1; bus.cfg_sel = 3'b000; bus.cfg_en = 1; bus.cfg_data = 8'hFF; step();
        bus.cfg_we = 0;
        send(0, 2'b00, 8'hFF, 8'hFF); step();
        bus.in_valid = 0; step();
        #1 chk("match_out", 32'(bus.out_match), 1);
        chk("match_irq", 32'(bus.irq), 1);
        chk("match_count", 32'(bus.irq_count), 1);
        bus.irq_clr = 1; step();
        bus.irq_clr = 0;
        #1 chk("clr_irq", 32'(bus.irq), 0);
        chk("clr_count", 32'(bus.irq_count), 1);
        step();
        send(0, 2'b00, 8'hFF, 8'hFF); step();
        bus.in_valid = 0; bus.irq_clr = 1; step();
        bus.irq_clr = 0;
        #1 chk("setwins_irq", 32'(bus.irq), 1);
        chk("setwins_count", 32'(bus.irq_count), 2);
        step();
        send(0, 2'b00, 8'hFF, 8'hFF); step();
        bus.in_valid = 0; bus.cfg_we = 1; bus.cfg_sel = 3'b000; bus.cfg_en = 1; bus.cfg_data = 8'h00; step();
        bus.cfg_we = 0;
        #1 chk("cfg_old_value_match", 32'(bus.out_match), 1);
        chk("cfg_old_value_count", 32'(bus.irq_count), 3);
        step();
        repeat (3) begin
            send(0, 2'b00, 8'h00, 8'h00); step();
        end
        bus.in_valid = 0;
        repeat (3) step();
        #1 chk("sat_count", 32'(bus.irq_count), 3);
        send(0, 2'b00, 8'h00, 8'h00); step();
        step();
        apply_reset();
        #1 chk("midrst_out_valid", 32'(bus.out_valid), 0);
        chk("midrst_irq", 32'(bus.irq), 0);
        chk("midrst_count", 32'(bus.irq_count), 0);
        chk("midrst_in_ready", 32'(bus.in_ready), 1);
        step();
        bus.in_valid = 0; rst_n = 1'b1;
        step();
        for (int i = 0; i < 600; i++) begin
            bus.in_valid = $urandom_range(0, 3) != 0;
            bus.in_bank = 1'($urandom);
            bus.in_op = 2'($urandom);
            bus.in_a = pick();
            bus.in_b = pick();
            bus.out_ready = $urandom_range(0, 3) != 0;
            bus.cfg_we = $urandom_range(0, 5) == 0;
            bus.cfg_sel = 3'($urandom);
            bus.cfg_en = $urandom_range(0, 3) != 0;
            bus.cfg_data = pick();
            bus.irq_clr = $urandom_range(0, 5) == 0;
            if (i % 200 == 199) apply_reset();
            else rst_n = 1'b1;
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
